// File: rtl/inst_rom_ctrl.sv
// rtl/inst_rom_ctrl.sv - instruction fetch responder assembling 32-bit words from a byte-wide memory
// Keeps the last fetched word; a repeat fetch of the same PC is served with no memory traffic.
module inst_rom_ctrl #(
  parameter int          ADDR_W   = 17,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rom_addr_i,
  input  logic              r_enable_i,
  output logic [31:0]       rom_data_o,
  output logic              rom_busy_o,
  output logic              rom_done_o,
  output logic              rom_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_data_i,
  input  logic              mem_ready_i
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-3:0]   base_word;
  logic [ADDR_W-3:0]   tag;
  logic                valid;
  logic [1:0]          beat;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [23:0]         word_buf;
  logic [31:0]         data_q;
  logic                err_flag;

  logic                hit;
  logic                miss;
  logic                start;
  logic                accept;
  logic                timeout_now;
  logic                wait_expired;

  assign hit          = valid && (rom_addr_i[ADDR_W-1:2] == tag);
  assign miss         = r_enable_i && !hit;
  assign wait_expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  // base is word aligned, so concatenating the beat index never needs a carry
  assign mem_addr_o = {base_word, beat};
  assign rom_data_o = data_q;

  always_comb begin
    state_next  = state;
    rom_busy_o  = 1'b0;
    rom_done_o  = 1'b0;
    rom_err_o   = 1'b0;
    mem_re_o    = 1'b0;
    start       = 1'b0;
    accept      = 1'b0;
    timeout_now = 1'b0;
    case (state)
      IDLE: begin
        // stall must be visible in the same cycle the miss appears
        rom_busy_o = miss && rst;
        if (miss) begin
          start      = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        rom_busy_o = 1'b1;
        mem_re_o   = 1'b1;
        if (mem_ready_i) begin
          accept = 1'b1;
          if (beat == 2'd3) begin
            state_next = DONE;
          end
        end else if (wait_expired) begin
          timeout_now = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        rom_done_o = 1'b1;
        rom_err_o  = err_flag;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base_word <= '0;
      tag       <= '0;
      valid     <= 1'b0;
      beat      <= 2'd0;
      wait_cnt  <= '0;
      word_buf  <= '0;
      data_q    <= '0;
      err_flag  <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        base_word <= rom_addr_i[ADDR_W-1:2];
        beat      <= 2'd0;
        wait_cnt  <= '0;
      end
      if (accept) begin
        case (beat)
          2'd0:    word_buf[7:0]   <= mem_data_i;
          2'd1:    word_buf[15:8]  <= mem_data_i;
          2'd2:    word_buf[23:16] <= mem_data_i;
          default: begin
            data_q <= {mem_data_i, word_buf};
            tag    <= base_word;
            valid  <= 1'b1;
          end
        endcase
        beat     <= beat + 2'd1;
        wait_cnt <= '0;
      end else if (state == FETCH) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (timeout_now) begin
        data_q   <= NOP_INST;
        valid    <= 1'b0;
        err_flag <= 1'b1;
      end
      if (state == DONE) begin
        err_flag <= 1'b0;
      end
    end
  end

endmodule
